// File: rtl/complex_vector_addsub_sequencer_if.sv
// Bundles the controller, operand/result RAM and add/sub unit signals seen by the sequencer.
// The master modport is the sequencer; the slave modport is everything it talks to.
interface complex_vector_addsub_sequencer_if #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 8
);
  logic              start;
  logic [ADDR_W:0]   vec_len;
  logic              op;
  logic              busy;
  logic              finish;
  logic              err;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] a_data;
  logic [DATA_W-1:0] b_data;
  logic              unit_start;
  logic              unit_ce;
  logic              unit_op;
  logic [DATA_W-1:0] unit_A;
  logic [DATA_W-1:0] unit_B;
  logic [DATA_W-1:0] unit_result;
  logic              unit_finish;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;

  modport master (
    input  start, vec_len, op, a_data, b_data, unit_result, unit_finish,
    output busy, finish, err, rd_en, rd_addr, unit_start, unit_ce, unit_op,
           unit_A, unit_B, wr_en, wr_addr, wr_data
  );

  modport slave (
    output start, vec_len, op, a_data, b_data, unit_result, unit_finish,
    input  busy, finish, err, rd_en, rd_addr, unit_start, unit_ce, unit_op,
           unit_A, unit_B, wr_en, wr_addr, wr_data
  );
endinterface

// File: rtl/complex_vector_addsub_sequencer.sv
// Walks a vector job element by element: read operands, start the add/sub unit,
// wait for its finish (with timeout), and write the complex result back.
module complex_vector_addsub_sequencer #(
  parameter int DATA_W  = 64,
  parameter int ADDR_W  = 8,
  parameter int TIMEOUT = 64
) (
  input  logic                            clk,
  input  logic                            rst_n,
  complex_vector_addsub_sequencer_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [ADDR_W:0] IDX_ONE = (ADDR_W + 1)'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RD,
    S_LAT,
    S_ISSUE,
    S_WAIT,
    S_WR,
    S_DONE
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W:0]   idx_q, idx_d;
  logic [ADDR_W:0]   len_q, len_d;
  logic              op_q, op_d;
  logic              err_q, err_d;
  logic              zfin_q, zfin_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic [TW-1:0]     timer_q, timer_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      len_q   <= '0;
      op_q    <= 1'b0;
      err_q   <= 1'b0;
      zfin_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      len_q   <= len_d;
      op_q    <= op_d;
      err_q   <= err_d;
      zfin_q  <= zfin_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    len_d   = len_q;
    op_d    = op_q;
    err_d   = err_q;
    zfin_d  = 1'b0;
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    timer_d = timer_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          err_d = 1'b0;
          // An empty job is acknowledged with a lone finish pulse and never leaves IDLE.
          if (bus.vec_len != '0) begin
            len_d   = bus.vec_len;
            op_d    = bus.op;
            idx_d   = '0;
            state_d = S_RD;
          end else begin
            zfin_d = 1'b1;
          end
        end
      end
      S_RD: begin
        state_d = S_LAT;
      end
      S_LAT: begin
        a_d     = bus.a_data;
        b_d     = bus.b_data;
        state_d = S_ISSUE;
      end
      S_ISSUE: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        if (bus.unit_finish) begin
          res_d   = bus.unit_result;
          state_d = S_WR;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          timer_d = timer_q + 1'b1;
        end
      end
      S_WR: begin
        if (idx_q == len_q - IDX_ONE) begin
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + IDX_ONE;
          state_d = S_RD;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  logic busy_w;
  assign busy_w = (state_q != S_IDLE) && (state_q != S_DONE);

  assign bus.busy       = busy_w;
  assign bus.unit_ce    = busy_w;
  assign bus.finish     = (state_q == S_DONE) || zfin_q;
  assign bus.err        = err_q;
  assign bus.rd_en      = (state_q == S_RD);
  assign bus.rd_addr    = idx_q[ADDR_W-1:0];
  assign bus.unit_start = (state_q == S_ISSUE);
  assign bus.unit_op    = op_q;
  assign bus.unit_A     = a_q;
  assign bus.unit_B     = b_q;
  assign bus.wr_en      = (state_q == S_WR);
  assign bus.wr_addr    = idx_q[ADDR_W-1:0];
  assign bus.wr_data    = res_q;

endmodule

// File: tb/tb_complex_vector_addsub_sequencer.sv
// Self-checking bench: RAM and add/sub unit models around the sequencer, with a
// write scoreboard filled when each job is launched and drained on every wr_en.
module tb_complex_vector_addsub_sequencer;

  localparam int DW = 64;
  localparam int AW = 8;
  localparam int TO = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  complex_vector_addsub_sequencer_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  complex_vector_addsub_sequencer #(
    .DATA_W (DW),
    .ADDR_W (AW),
    .TIMEOUT(TO)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } wr_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [DW-1:0] memA[256];
  logic [DW-1:0] memB[256];
  wr_t sbQ[$];
  int rdCount = 0, startCount = 0, wrCount = 0, finishCount = 0, busyCount = 0;
  int lastFinishCyc = 0;
  int acceptCyc = 0;
  logic [DW-1:0] lastWrData = '0;
  int unitK = 3;
  bit unitHang = 1'b0;
  int uCnt = 0;

  function automatic logic [DW-1:0] calc(input logic [DW-1:0] a, input logic [DW-1:0] b,
                                         input logic o);
    logic [DW/2-1:0] re, im;
    re = o ? a[DW-1:DW/2] - b[DW-1:DW/2] : a[DW-1:DW/2] + b[DW-1:DW/2];
    im = o ? a[DW/2-1:0] - b[DW/2-1:0] : a[DW/2-1:0] + b[DW/2-1:0];
    return {re, im};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic checkZeroOutputs(input string tag);
    checkOutput({tag, "_ctrl"}, 64'({bus.busy, bus.finish, bus.err, bus.rd_en, bus.unit_start,
                                     bus.unit_ce, bus.unit_op, bus.wr_en, bus.rd_addr,
                                     bus.wr_addr}), 64'd0);
    checkOutput({tag, "_data"}, bus.unit_A | bus.unit_B | bus.wr_data, 64'd0);
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Operand RAM with one cycle of read latency
  always @(posedge clk) begin
    if (bus.rd_en) begin
      bus.a_data <= memA[bus.rd_addr];
      bus.b_data <= memB[bus.rd_addr];
    end
  end

  // Add/sub unit: finish arrives unitK cycles after the unit_start cycle
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      uCnt = 0;
      bus.unit_finish <= 1'b0;
      bus.unit_result <= '0;
    end else begin
      bus.unit_finish <= 1'b0;
      if (bus.unit_start && !unitHang) begin
        if (unitK == 1) begin
          bus.unit_finish <= 1'b1;
          bus.unit_result <= calc(bus.unit_A, bus.unit_B, bus.unit_op);
        end else begin
          uCnt = unitK - 1;
        end
      end else if (uCnt > 0) begin
        uCnt = uCnt - 1;
        if (uCnt == 0) begin
          bus.unit_finish <= 1'b1;
          bus.unit_result <= calc(bus.unit_A, bus.unit_B, bus.unit_op);
        end
      end
    end
  end

  wr_t expWr;
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.rd_en) rdCount++;
      if (bus.unit_start) startCount++;
      if (bus.busy) busyCount++;
      if (bus.finish) begin
        finishCount++;
        lastFinishCyc = cyc;
      end
      if (bus.wr_en) begin
        wrCount++;
        lastWrData = bus.wr_data;
        if (sbQ.size() == 0) begin
          checkOutput("wr_unexpected", 64'(bus.wr_en), 64'd0);
        end else begin
          expWr = sbQ.pop_front();
          checkOutput("wr_addr", 64'(bus.wr_addr), 64'(expWr.addr));
          checkOutput("wr_data", bus.wr_data, expWr.data);
        end
      end
    end
  end

  task automatic pushExpected(input int n, input logic o);
    wr_t e;
    for (int i = 0; i < n; i++) begin
      e.addr = AW'(i);
      e.data = calc(memA[i], memB[i], o);
      sbQ.push_back(e);
    end
  endtask

  task automatic applyStimulus(input int n, input logic o, input bit hold);
    @(posedge clk);
    #1;
    bus.start   = 1'b1;
    bus.vec_len = (AW + 1)'(n);
    bus.op      = o;
    acceptCyc   = cyc;
    if (!unitHang) pushExpected(n, o);
    if (!hold) begin
      @(posedge clk);
      #1;
      bus.start = 1'b0;
    end
  endtask

  task automatic waitFinish(input int fc0);
    int i;
    i = 0;
    while (finishCount == fc0 && i < 3000) begin
      @(posedge clk);
      i++;
    end
    #1;
    checkOutput("finish_count", 64'(finishCount - fc0), 64'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int fc0, rc0, sc0, wc0, bc0, f1;

    bus.start   = 1'b0;
    bus.vec_len = '0;
    bus.op      = 1'b0;
    for (int i = 0; i < 256; i++) begin
      memA[i] = {$urandom, $urandom};
      memB[i] = {$urandom, $urandom};
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkZeroOutputs("reset");
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // N=4 add, unit latency 3
    unitK = 3;
    fc0 = finishCount; rc0 = rdCount; sc0 = startCount; wc0 = wrCount;
    applyStimulus(4, 1'b0, 1'b0);
    checkOutput("t1_busy", 64'(bus.busy), 64'd1);
    waitFinish(fc0);
    checkOutput("t1_latency", 64'(lastFinishCyc - acceptCyc), 64'd29);
    checkOutput("t1_reads", 64'(rdCount - rc0), 64'd4);
    checkOutput("t1_starts", 64'(startCount - sc0), 64'd4);
    checkOutput("t1_writes", 64'(wrCount - wc0), 64'd4);
    checkOutput("t1_err", 64'(bus.err), 64'd0);

    // Subtract with known operands
    memA[0] = {32'h0000000A, 32'h00000005};
    memB[0] = {32'h00000003, 32'h00000007};
    fc0 = finishCount;
    applyStimulus(1, 1'b1, 1'b0);
    checkOutput("t2_unit_op", 64'(bus.unit_op), 64'd1);
    waitFinish(fc0);
    checkOutput("t2_result", lastWrData, 64'h00000007_FFFFFFFE);
    checkOutput("t2_latency", 64'(lastFinishCyc - acceptCyc), 64'd8);

    // Empty job
    fc0 = finishCount; rc0 = rdCount; sc0 = startCount; wc0 = wrCount; bc0 = busyCount;
    applyStimulus(0, 1'b0, 1'b0);
    waitFinish(fc0);
    checkOutput("t3_latency", 64'(lastFinishCyc - acceptCyc), 64'd1);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("t3_no_traffic", 64'({rdCount - rc0, startCount - sc0}), 64'd0);
    checkOutput("t3_no_write", 64'(wrCount - wc0), 64'd0);
    checkOutput("t3_no_busy", 64'(busyCount - bc0), 64'd0);

    // Unit never finishes: timeout abort, then err cleared by next start
    unitHang = 1'b1;
    fc0 = finishCount; wc0 = wrCount;
    applyStimulus(3, 1'b0, 1'b0);
    waitFinish(fc0);
    checkOutput("t4_latency", 64'(lastFinishCyc - acceptCyc), 64'(3 + TO + 1));
    checkOutput("t4_no_write", 64'(wrCount - wc0), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t4_err_sticky", 64'(bus.err), 64'd1);
    unitHang = 1'b0;
    unitK = 2;
    fc0 = finishCount;
    applyStimulus(1, 1'b0, 1'b0);
    checkOutput("t4_err_cleared", 64'(bus.err), 64'd0);
    waitFinish(fc0);
    checkOutput("t4_err_after", 64'(bus.err), 64'd0);

    // Start held high through an N=2 job
    unitK = 1;
    fc0 = finishCount;
    applyStimulus(2, 1'b0, 1'b1);
    waitFinish(fc0);
    checkOutput("t6_lat1", 64'(lastFinishCyc - acceptCyc), 64'd11);
    f1 = lastFinishCyc;
    pushExpected(2, 1'b0);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    checkOutput("t6_second_busy", 64'(bus.busy), 64'd1);
    waitFinish(fc0 + 1);
    checkOutput("t6_lat2", 64'(lastFinishCyc - (f1 + 1)), 64'd11);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("t6_jobs", 64'(finishCount - fc0), 64'd2);

    // Reset asserted during WAIT of element 2
    unitK = 10;
    fc0 = finishCount; wc0 = wrCount; sc0 = startCount;
    applyStimulus(4, 1'b0, 1'b0);
    for (int i = 0; i < 500 && wrCount < wc0 + 2; i++) @(posedge clk);
    #1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t5_in_wait", 64'(startCount - sc0), 64'd3);
    rst_n = 1'b0;
    #1;
    checkZeroOutputs("t5_reset");
    sbQ.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    wc0 = wrCount;
    repeat (60) @(posedge clk);
    #1;
    checkOutput("t5_no_finish", 64'(finishCount - fc0), 64'd0);
    checkOutput("t5_no_write", 64'(wrCount - wc0), 64'd0);
    checkOutput("t5_idle", 64'(bus.busy), 64'd0);

    checkOutput("sb_empty", 64'(sbQ.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
